bcd_para_binario: RTL and testbench

BCD_PARA_BINARIO -- requirements
Module: bcd_para_binario

---
 rtl/bcd_para_binario.sv | 125 ++++++++++++
 tb/tb_bcd_para_binario.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_para_binario.sv
// Signed packed-BCD to 32-bit two's-complement converter.
// One reverse double-dabble step per clock, with a start/valid handshake.
module bcd_para_binario #(
  parameter int DIGITOS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   sinal,
  input  logic [4*DIGITOS-1:0]   digitos,
  output logic [31:0]            numero,
  output logic                   pronto,
  output logic                   erro,
  output logic                   ocupado
);

  localparam int LARG = 4 * DIGITOS;
  localparam int CW   = $clog2(LARG + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(LARG - 1);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, FIM} estado_t;

  estado_t          estado_q;
  logic             sinal_q;
  logic [LARG-1:0]  bcd_q;
  logic [LARG-1:0]  bin_q;
  logic [CW-1:0]    cnt_q;
  logic             erro_pend_q;
  logic             espera_q;
  logic [31:0]      numero_q;
  logic             pronto_q;
  logic             erro_q;
  logic             ocupado_q;

  logic [LARG-1:0]  bcd_sh;
  logic [LARG-1:0]  bcd_d;
  logic [LARG-1:0]  bin_d;
  logic [DIGITOS-1:0] nib_inv;
  logic [31:0]      magnitude;
  logic [31:0]      resultado;

  // Shift the {bcd, bin} pair right; the LSB of bcd drops into the MSB of bin.
  assign bcd_sh = bcd_q >> 1;
  assign bin_d  = {bcd_q[0], bin_q[LARG-1:1]};

  genvar gi;
  generate
    for (gi = 0; gi < DIGITOS; gi++) begin : g_nib
      assign bcd_d[4*gi +: 4] = (bcd_sh[4*gi +: 4] >= 4'd8) ? bcd_sh[4*gi +: 4] - 4'd3
                                                           : bcd_sh[4*gi +: 4];
      assign nib_inv[gi] = digitos[4*gi +: 4] > 4'd9;
    end
    if (LARG >= 32) begin : g_trunc
      // The largest 9-digit value still fits in 30 bits.
      assign magnitude = bin_q[31:0];
    end else begin : g_ext
      assign magnitude = {{(32-LARG){1'b0}}, bin_q};
    end
  endgenerate

  assign resultado = sinal_q ? (~magnitude + 32'd1) : magnitude;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      sinal_q     <= 1'b0;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      erro_pend_q <= 1'b0;
      espera_q    <= 1'b0;
      numero_q    <= '0;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            sinal_q   <= sinal;
            bcd_q     <= digitos;
            bin_q     <= '0;
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
            if (|nib_inv) begin
              // An error result spends one extra cycle in FIM before reporting.
              erro_pend_q <= 1'b1;
              espera_q    <= 1'b1;
              estado_q    <= FIM;
            end else begin
              erro_pend_q <= 1'b0;
              espera_q    <= 1'b0;
              estado_q    <= CONVERTE;
            end
          end
        end
        CONVERTE: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == ULTIMO) estado_q <= FIM;
        end
        FIM: begin
          if (espera_q) begin
            espera_q <= 1'b0;
          end else begin
            numero_q  <= erro_pend_q ? 32'd0 : resultado;
            erro_q    <= erro_pend_q;
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
            estado_q  <= OCIOSO;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign numero  = numero_q;
  assign pronto  = pronto_q;
  assign erro    = erro_q;
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_bcd_para_binario.sv
// Randomized self-checking bench for bcd_para_binario (4- and 9-digit builds)
// against a decimal-arithmetic reference model.
module tb_bcd_para_binario;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic        sinal = 1'b0;
  logic        sel9 = 1'b0;
  logic [35:0] digitos = '0;

  logic        iniciar4, iniciar9;
  logic [31:0] numero4, numero9;
  logic        pronto4, pronto9, erro4, erro9, ocupado4, ocupado9;
  logic [31:0] numero_m;
  logic        pronto_m, erro_m, ocupado_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign iniciar4 = iniciar & ~sel9;
  assign iniciar9 = iniciar & sel9;
  assign numero_m  = sel9 ? numero9  : numero4;
  assign pronto_m  = sel9 ? pronto9  : pronto4;
  assign erro_m    = sel9 ? erro9    : erro4;
  assign ocupado_m = sel9 ? ocupado9 : ocupado4;

  bcd_para_binario #(.DIGITOS(4)) dut4 (
    .clock(clock), .reset(reset), .iniciar(iniciar4), .sinal(sinal),
    .digitos(digitos[15:0]), .numero(numero4), .pronto(pronto4),
    .erro(erro4), .ocupado(ocupado4)
  );

  bcd_para_binario #(.DIGITOS(9)) dut9 (
    .clock(clock), .reset(reset), .iniciar(iniciar9), .sinal(sinal),
    .digitos(digitos), .numero(numero9), .pronto(pronto9),
    .erro(erro9), .ocupado(ocupado9)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: read the digits as a decimal number, then apply the sign.
  function automatic void ref_model(input logic [35:0] d, input int nd, input logic s,
                                    output logic [31:0] num, output logic err);
    longint val;
    logic [3:0] nib;
    val = 0;
    err = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      nib = d[4*i +: 4];
      if (nib > 4'd9) err = 1'b1;
      val = val * 10 + longint'(nib);
    end
    if (err) num = 32'd0;
    else     num = s ? 32'(-val) : 32'(val);
  endfunction

  function automatic logic [35:0] rand_bcd(input int nd);
    logic [35:0] d;
    d = '0;
    for (int i = 0; i < nd; i++) begin
      if ($urandom_range(0, 15) == 0) d[4*i +: 4] = 4'($urandom_range(10, 15));
      else                            d[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return d;
  endfunction

  task automatic convert(input logic [35:0] d, input logic s, input logic keep, input logic pulse);
    int nd, exp_lat, n;
    logic [31:0] exp_num, prev_num;
    logic exp_err, prev_err, seen;
    nd = sel9 ? 9 : 4;
    ref_model(d, nd, s, exp_num, exp_err);
    exp_lat = exp_err ? 2 : 4 * nd + 1;
    @(negedge clock);
    digitos  = d;
    sinal    = s;
    iniciar  = 1'b1;
    prev_num = numero_m;
    prev_err = erro_m;
    @(posedge clock);
    #1;
    if (!keep) iniciar = 1'b0;
    check_eq("ocupado_inicio", 64'(ocupado_m), 64'd1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 60) begin
      digitos = {4'($urandom), 32'($urandom)};
      sinal   = 1'($urandom);
      if (pulse) iniciar = (n + 1 == 3) || (n + 1 == 10);
      @(posedge clock);
      #1;
      n++;
      if (pronto_m) begin
        seen = 1'b1;
      end else begin
        check_eq("ocupado_durante", 64'(ocupado_m), 64'd1);
        check_eq("numero_retido", 64'(numero_m), 64'(prev_num));
        check_eq("erro_retido", 64'(erro_m), 64'(prev_err));
      end
    end
    if (pulse) iniciar = 1'b0;
    if (!seen) n = 999;
    check_eq("latencia", 64'(n), 64'(exp_lat));
    check_eq("numero", 64'(numero_m), 64'(exp_num));
    check_eq("erro", 64'(erro_m), 64'(exp_err));
    check_eq("ocupado_fim", 64'(ocupado_m), 64'd0);
    $display("conv D=%0d digitos=%h sinal=%b -> numero=%h erro=%b latencia=%0d",
             nd, d, s, numero_m, erro_m, n);
  endtask

  task automatic idle(input int ciclos);
    iniciar = 1'b0;
    for (int i = 0; i < ciclos; i++) begin
      @(posedge clock);
      #1;
      check_eq("pronto_ocioso", 64'(pronto_m), 64'd0);
      check_eq("ocupado_ocioso", 64'(ocupado_m), 64'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] d;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_numero", 64'(numero_m), 64'd0);
    check_eq("reset_pronto", 64'(pronto_m), 64'd0);
    check_eq("reset_erro", 64'(erro_m), 64'd0);
    check_eq("reset_ocupado", 64'(ocupado_m), 64'd0);
    reset = 1'b0;

    convert(36'h0042, 1'b0, 1'b0, 1'b0); idle(1);
    convert(36'h9999, 1'b1, 1'b0, 1'b0); idle(1);
    convert(36'h0000, 1'b1, 1'b0, 1'b0); idle(1);
    convert(36'h12A4, 1'b0, 1'b0, 1'b0); idle(1);
    convert(36'h0007, 1'b0, 1'b0, 1'b0); idle(1);

    // Requests during a conversion are dropped, not queued.
    convert(36'h1234, 1'b0, 1'b0, 1'b1); idle(20);

    // Reset at edge k+8 discards the conversion in flight.
    @(negedge clock);
    digitos = 36'h5678;
    sinal   = 1'b0;
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_eq("rst_meio_numero", 64'(numero_m), 64'd0);
    check_eq("rst_meio_pronto", 64'(pronto_m), 64'd0);
    check_eq("rst_meio_erro", 64'(erro_m), 64'd0);
    check_eq("rst_meio_ocupado", 64'(ocupado_m), 64'd0);
    reset = 1'b0;
    idle(20);
    convert(36'h0815, 1'b1, 1'b0, 1'b0); idle(1);

    // iniciar held high: the second conversion starts on the first idle edge.
    convert(36'h3141, 1'b0, 1'b1, 1'b0);
    convert(36'h2718, 1'b1, 1'b0, 1'b0); idle(1);

    for (int i = 0; i < 30; i++) begin
      d = rand_bcd(4);
      convert(d, 1'($urandom), 1'b0, 1'b0);
      idle(1);
    end

    sel9 = 1'b1;
    idle(1);
    convert(36'h999999999, 1'b0, 1'b0, 1'b0); idle(1);
    for (int i = 0; i < 6; i++) begin
      d = rand_bcd(9);
      convert(d, 1'($urandom), 1'b0, 1'b0);
      idle(1);
    end
    sel9 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
